// File: rtl/regfile_scoreboard.sv
// Register file (x0..x31, x0 hardwired to zero) with a busy-bit scoreboard
// for the ID stage. Producers mark their destination busy at issue and clear
// it at writeback; stall is raised while an ID source operand is still
// outstanding.
//
// Build option: REGFILE_WRITE_BYPASS_EN
//   defined   - a same-cycle writeback is forwarded onto rd1/rd2
//   undefined - rd1/rd2 return the stored value; the forwarding unit bypasses
module regfile_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        wvalid,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        stall,
  output logic [5:0]  busy_count
);

  logic [63:0] regs_q [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [5:0]  count_q;
  logic [5:0]  count_d;
  logic        wr_en;
  logic        iss_en;
  logic        pend1;
  logic        pend2;

  assign wr_en  = wvalid && (wa != 5'd0);
  assign iss_en = issue_valid && (issue_rd != 5'd0);

  // Register storage; entry 0 is only ever reset, so x0 reads as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  // Combinational read ports, optionally forwarding the writeback in flight.
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en && (wa == ra1)) rd1 = wd;
    if (wr_en && (wa == ra2)) rd2 = wd;
`endif
  end

  // Next busy vector: clear on writeback, set on issue (set wins), flush wipes all.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wa] = 1'b0;
    if (iss_en) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    count_d = '0;
    for (int i = 1; i < 32; i++) begin
      count_d = count_d + {5'd0, busy_d[i]};
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // A source is pending if busy and not being written back this very cycle.
  always_comb begin
    pend1 = busy_q[ra1] && !(wvalid && (wa == ra1));
    pend2 = busy_q[ra2] && !(wvalid && (wa == ra2));
    stall = pend1 || pend2;
  end

  assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by a randomized
// run checked against a simple array-based reference model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        wvalid;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;
  logic [5:0]  busy_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] regs_m [32];
  bit          busy_m [32];

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wvalid(wvalid), .wa(wa), .wd(wd), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .stall(stall), .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += busy_m[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [63:0] model_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wvalid && wa == ra) return wd;
`endif
    return regs_m[ra];
  endfunction

  function automatic logic model_stall();
    logic s1, s2;
    s1 = busy_m[ra1] && !(wvalid && wa == ra1);
    s2 = busy_m[ra2] && !(wvalid && wa == ra2);
    return s1 || s2;
  endfunction

  task automatic set_in(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic wv, input logic [4:0] a, input logic [63:0] d,
                        input logic iv, input logic [4:0] ir, input logic fl);
    reset = rst; ra1 = r1; ra2 = r2; wvalid = wv; wa = a; wd = d;
    issue_valid = iv; issue_rd = ir; flush = fl;
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_m[i] = 64'd0;
        busy_m[i] = 1'b0;
      end
    end else begin
      if (wvalid && wa != 5'd0) begin
        regs_m[wa] = wd;
        busy_m[wa] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 5'd3, 5'd4, 1, 5'd5, 64'hDEAD, 1, 5'd8, 0);
    @(negedge clk);
    tick();
    set_in(1, 5'd5, 5'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (rd1 !== 64'd0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== 64'd0) begin errors++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", busy_count); end
    tick();
  endtask

  task automatic test_write_read();
    set_in(1, 5'd0, 5'd0, 1, 5'd5, 64'h1234, 0, 5'd0, 0);
    @(negedge clk); tick();
    set_in(1, 5'd5, 5'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (rd1 !== 64'h1234) begin errors++; $display("FAIL write_x5 got=%h exp=1234", rd1); end
    tick();
    set_in(1, 5'd0, 5'd5, 1, 5'd0, 64'hFFFF, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (rd1 !== 64'd0) begin errors++; $display("FAIL x0_same_cycle got=%h exp=0", rd1); end
    tick();
    set_in(1, 5'd0, 5'd5, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (rd1 !== 64'd0) begin errors++; $display("FAIL x0_after_write got=%h exp=0", rd1); end
    checks++; if (rd2 !== 64'h1234) begin errors++; $display("FAIL x5_kept got=%h exp=1234", rd2); end
    tick();
  endtask

  task automatic test_issue_stall();
    logic [63:0] exp_rd2;
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd7, 0);
    @(negedge clk); tick();
    set_in(1, 5'd0, 5'd7, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy7_stall got=%b exp=1", stall); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL busy7_count got=%0d exp=1", busy_count); end
    tick();
    set_in(1, 5'd0, 5'd7, 1, 5'd7, 64'hA5A5_0000_C3C3_0707, 0, 5'd0, 0);
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_rd2 = 64'hA5A5_0000_C3C3_0707;
`else
    exp_rd2 = 64'd0;
`endif
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb7_stall got=%b exp=0", stall); end
    checks++; if (rd2 !== exp_rd2) begin errors++; $display("FAIL wb7_rd2 got=%h exp=%h", rd2, exp_rd2); end
    tick();
    set_in(1, 5'd0, 5'd7, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL wb7_count got=%0d exp=0", busy_count); end
    checks++; if (rd2 !== 64'hA5A5_0000_C3C3_0707) begin errors++; $display("FAIL wb7_stored got=%h", rd2); end
    tick();
  endtask

  task automatic test_set_wins();
    set_in(1, 5'd0, 5'd0, 1, 5'd9, 64'h99, 1, 5'd9, 0);
    @(negedge clk); tick();
    set_in(1, 5'd9, 5'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL setwins_count got=%0d exp=1", busy_count); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL setwins_stall got=%b exp=1", stall); end
    tick();
    set_in(1, 5'd0, 5'd0, 1, 5'd9, 64'h98, 0, 5'd0, 0);
    @(negedge clk); tick();
  endtask

  task automatic test_flush();
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd3, 0);
    @(negedge clk); tick();
    issue_rd = 5'd4;
    @(negedge clk); tick();
    issue_rd = 5'd10;
    @(negedge clk); tick();
    set_in(1, 5'd3, 5'd10, 0, 5'd0, 64'd0, 1, 5'd11, 1);
    @(negedge clk);
    checks++; if (busy_count !== 6'd3) begin errors++; $display("FAIL preflush_count got=%0d exp=3", busy_count); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL preflush_stall got=%b exp=1", stall); end
    tick();
    set_in(1, 5'd3, 5'd4, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", busy_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_3_4 got=%b exp=0", stall); end
    tick();
    set_in(1, 5'd10, 5'd11, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_10_11 got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_reset_priority();
    set_in(1, 5'd0, 5'd0, 1, 5'd2, 64'h22, 1, 5'd2, 0);
    @(negedge clk); tick();
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd6, 0);
    @(negedge clk); tick();
    set_in(0, 5'd2, 5'd6, 1, 5'd2, 64'h5555, 1, 5'd6, 0);
    @(negedge clk);
    checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL prerst_count got=%0d exp=2", busy_count); end
    tick();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 5'(i), 5'(31 - i), 0, 5'd0, 64'd0, 0, 5'd0, 0);
      @(negedge clk);
      checks++;
      if (rd1 !== 64'd0 || rd2 !== 64'd0 || stall !== 1'b0 || busy_count !== 6'd0) begin
        errors++;
        $display("FAIL rstprio_x%0d rd1=%h rd2=%h stall=%b count=%0d exp all 0", i, rd1, rd2, stall, busy_count);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [63:0] e1, e2;
    logic es;
    int ec;
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 63) != 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
             {$urandom, $urandom},
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 9)),
             ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      @(negedge clk);
      e1 = model_rd(ra1); e2 = model_rd(ra2); es = model_stall(); ec = model_count();
      checks++; if (rd1 !== e1) begin errors++; $display("FAIL rnd_rd1 n=%0d got=%h exp=%h", n, rd1, e1); end
      checks++; if (rd2 !== e2) begin errors++; $display("FAIL rnd_rd2 n=%0d got=%h exp=%h", n, rd2, e2); end
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, es); end
      checks++; if (busy_count !== 6'(ec)) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, busy_count, ec); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = 64'd0;
      busy_m[i] = 1'b0;
    end
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 64'd0, 0, 5'd0, 0);
    test_reset();
    test_write_read();
    test_issue_stall();
    test_set_wins();
    test_flush();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
